// File: rtl/magnitude_bcd_converter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : magnitude_bcd_converter                                    |
// | Description : Serial binary-to-packed-BCD converter (shift-add-3), one   |
// |               magnitude bit per clock, with a registered sign flag and   |
// |               valid/ready handshakes on both sides.                      |
// | Options     : BCD_ZERO_BLANK_EN adds a per-digit leading-zero blank      |
// |               output (blank), registered on entry to DONE.               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module magnitude_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      mag,
  input  logic                  neg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  busy
`ifdef BCD_ZERO_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  // DIGITS must satisfy 10^DIGITS > 2^WIDTH - 1, otherwise the top of the
  // accumulator overflows and high-order digits are silently lost.
  localparam int c_acc_w = 4 * DIGITS;
  localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_shift;
  logic [c_acc_w-1:0]   r_acc;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_sign;

  logic                 w_accept;
  logic                 w_last_shift;
  logic [c_acc_w-1:0]   w_adj;
  logic [c_acc_w-1:0]   w_acc_next;
  logic [WIDTH-1:0]     w_shift_next;
  logic                 w_unused_msb;

  assign w_accept     = (r_state == S_IDLE) && in_valid;
  assign w_last_shift = (r_state == S_SHIFT) && (r_cnt == c_last_cnt);

  // Per-digit add-3 correction; no carry crosses a digit boundary.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit_adj
    always_comb begin
      w_adj[4*i +: 4] = r_acc[4*i +: 4];
      if (r_acc[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // Shift {accumulator, magnitude} left by one; the accumulator MSB falls off.
  assign {w_unused_msb, w_acc_next, w_shift_next} = {w_adj, r_shift, 1'b0};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake/status decode.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (r_cnt == c_last_cnt) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Conversion datapath: load on accept, one shift-add-3 step per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
    end else if (w_accept) begin
      r_shift <= mag;
      r_acc   <= '0;
      r_cnt   <= '0;
      // Negative zero is reported as positive.
      r_sign  <= neg & (mag != '0);
    end else if (r_state == S_SHIFT) begin
      r_shift <= w_shift_next;
      r_acc   <= w_acc_next;
      r_cnt   <= r_cnt + c_cnt_w'(1);
    end
  end

  assign bcd  = r_acc;
  assign sign = r_sign;

`ifdef BCD_ZERO_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank_next;

  // Units digit is never blanked so a zero result still shows "0".
  assign w_blank_next[0] = 1'b0;
  for (genvar i = 1; i < DIGITS; i++) begin : g_blank
    assign w_blank_next[i] = (w_acc_next[c_acc_w-1:4*i] == '0);
  end

  // Blank mask is captured from the final accumulator on the edge into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blank <= '0;
    end else if (w_last_shift) begin
      r_blank <= w_blank_next;
    end
  end

  assign blank = r_blank;
`else
  logic w_unused_last;
  assign w_unused_last = w_last_shift;
`endif

endmodule
`default_nettype wire

// File: tb/tb_magnitude_bcd_converter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_magnitude_bcd_converter                                 |
// | Description : Directed self-checking bench for magnitude_bcd_converter.  |
// |               Blank checks are compiled in with BCD_ZERO_BLANK_EN.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_magnitude_bcd_converter;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     mag;
  logic                 neg;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*DIGITS-1:0]  bcd;
  logic                 sign;
  logic                 busy;
`ifdef BCD_ZERO_BLANK_EN
  logic [DIGITS-1:0]    blank;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  magnitude_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mag       (mag),
    .neg       (neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .sign      (sign),
    .busy      (busy)
`ifdef BCD_ZERO_BLANK_EN
    ,
    .blank     (blank)
`endif
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid (bounded); returns cycles counted from the accept edge.
  task automatic wait_result(output int lat);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      step();
      if (out_valid) lat = k;
    end
  endtask

  // One full transaction: accept, wait, check, consume.
  task automatic run_conv(input logic [31:0] m, input logic n,
                          input logic [39:0] exp_bcd, input logic exp_sign);
    int lat;
    check_val("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    mag = m; neg = n; in_valid = 1'b1;
    step();
    in_valid = 1'b0; mag = '0; neg = 1'b0;
    check_val("busy_after_accept", {63'd0, busy}, 64'd1);
    wait_result(lat);
    check_val("latency", 64'(lat), 64'd32);
    check_val("bcd", {24'd0, bcd}, {24'd0, exp_bcd});
    check_val("sign", {63'd0, sign}, {63'd0, exp_sign});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_val("out_valid_after_consume", {63'd0, out_valid}, 64'd0);
    check_val("in_ready_after_consume", {63'd0, in_ready}, 64'd1);
    check_val("bcd_held_in_idle", {24'd0, bcd}, {24'd0, exp_bcd});
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mag = '0; neg = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_bcd", {24'd0, bcd}, 64'd0);
    check_val("rst_sign", {63'd0, sign}, 64'd0);
`ifdef BCD_ZERO_BLANK_EN
    check_val("rst_blank", {54'd0, blank}, 64'd0);
`endif

    // Directed conversions
    run_conv(32'd0, 1'b0, 40'h0000000000, 1'b0);
`ifdef BCD_ZERO_BLANK_EN
    check_val("blank_zero", {54'd0, blank}, {54'd0, 10'b1111111110});
`endif
    run_conv(32'hFFFFFFFF, 1'b0, 40'h4294967295, 1'b0);
`ifdef BCD_ZERO_BLANK_EN
    check_val("blank_max", {54'd0, blank}, 64'd0);
`endif
    run_conv(32'd12345, 1'b1, 40'h0000012345, 1'b1);
`ifdef BCD_ZERO_BLANK_EN
    check_val("blank_12345", {54'd0, blank}, {54'd0, 10'b1111100000});
`endif
    run_conv(32'd0, 1'b1, 40'h0000000000, 1'b0);
    run_conv(32'd305, 1'b0, 40'h0000000305, 1'b0);
`ifdef BCD_ZERO_BLANK_EN
    check_val("blank_305", {54'd0, blank}, {54'd0, 10'b1111111000});
`endif
    run_conv(32'd1000000000, 1'b0, 40'h1000000000, 1'b0);
    run_conv(32'd99, 1'b1, 40'h0000000099, 1'b1);

    // Backpressure: hold a result while a new request waits
    mag = 32'd54321; neg = 1'b1; in_valid = 1'b1;
    step();
    mag = 32'd7; neg = 1'b0;
    wait_result(lat);
    check_val("bp_latency", 64'(lat), 64'd32);
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check_val("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check_val("bp_bcd", {24'd0, bcd}, 64'h54321);
      check_val("bp_sign", {63'd0, sign}, 64'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_val("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0; mag = '0;
    check_val("bp_second_accept_busy", {63'd0, busy}, 64'd1);
    wait_result(lat);
    check_val("bp_second_latency", 64'(lat), 64'd32);
    check_val("bp_second_bcd", {24'd0, bcd}, 64'h7);
    check_val("bp_second_sign", {63'd0, sign}, 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during SHIFT cycle 15
    mag = 32'd999; neg = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; mag = '0; neg = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check_val("mid_busy_before_rst", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_val("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("mid_rst_bcd", {24'd0, bcd}, 64'd0);
    check_val("mid_rst_sign", {63'd0, sign}, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    check_val("mid_rst_no_pulse", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
